// File: rtl/mandel_scan_ctrl.sv
// rtl/mandel_scan_ctrl.sv - raster-scan sequencer feeding a shared Mandelbrot iteration engine
//
// Walks a cfg_width x cfg_height grid of Q4.(W_COORD-4) coordinates, issues one
// engine request per pixel, maps each iteration count to a pixel value and hands
// it to the draw sink. Repeats for cfg_num_frames frames, idling cfg_pause+1
// cycles between frames.
//
// Ports:
//   sync_clk, rst_n                   clock, asynchronous active-low reset
//   start, abort                      run control; start ignored while busy, abort forces IDLE
//   cfg_*                             run configuration, latched on an accepted start
//   eng_req_valid/ready, eng_cre/cim  request channel to the iteration engine
//   eng_rsp_valid, eng_rsp_iter       result channel from the iteration engine
//   pix_valid/ready, pix_x/y/n/flush  pixel channel to the draw sink
//   frame_done, frame_clear, run_done one-cycle strobes
//   busy                              high whenever the sequencer is outside IDLE
module mandel_scan_ctrl #(
    parameter int W_COORD  = 32,
    parameter int W_DIM    = 10,
    parameter int W_ITER   = 10,
    parameter int MAX_ITER = 1000
) (
    input  logic               sync_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [W_DIM-1:0]   cfg_width,
    input  logic [W_DIM-1:0]   cfg_height,
    input  logic [W_COORD-1:0] cfg_xstart,
    input  logic [W_COORD-1:0] cfg_ystart,
    input  logic [W_COORD-1:0] cfg_xincr,
    input  logic [W_COORD-1:0] cfg_yincr,
    input  logic [7:0]         cfg_num_frames,
    input  logic [15:0]        cfg_pause,
    output logic               eng_req_valid,
    input  logic               eng_req_ready,
    output logic [W_COORD-1:0] eng_cre,
    output logic [W_COORD-1:0] eng_cim,
    input  logic               eng_rsp_valid,
    input  logic [W_ITER-1:0]  eng_rsp_iter,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [W_DIM-1:0]   pix_x,
    output logic [W_DIM-1:0]   pix_y,
    output logic [W_ITER-1:0]  pix_n,
    output logic               pix_flush,
    output logic               frame_done,
    output logic               frame_clear,
    output logic               busy,
    output logic               run_done
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_PAUSE} state_t;

    localparam logic [W_DIM-1:0] DIM_ONE = W_DIM'(1);

    state_t             state_q, state_d;
    logic [W_DIM-1:0]   width_q, width_d, height_q, height_d;
    logic [W_COORD-1:0] xstart_q, xstart_d, ystart_q, ystart_d;
    logic [W_COORD-1:0] xincr_q, xincr_d, yincr_q, yincr_d;
    logic [7:0]         nframes_q, nframes_d;
    logic [15:0]        pause_q, pause_d;
    logic [W_DIM-1:0]   x_q, x_d, y_q, y_d;
    logic [W_COORD-1:0] xr_q, xr_d, yr_q, yr_d;
    logic [3:0]         mod10_q, mod10_d;
    logic [7:0]         frame_q, frame_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [W_ITER-1:0]  n_q, n_d;
    logic               frame_done_d, frame_clear_d, run_done_d;
    logic               eng_req_valid_q, pix_valid_q, pix_flush_q, busy_q;
    logic               frame_done_q, frame_clear_q, run_done_q;

    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        xstart_d      = xstart_q;
        ystart_d      = ystart_q;
        xincr_d       = xincr_q;
        yincr_d       = yincr_q;
        nframes_d     = nframes_q;
        pause_d       = pause_q;
        x_d           = x_q;
        y_d           = y_q;
        xr_d          = xr_q;
        yr_d          = yr_q;
        mod10_d       = mod10_q;
        frame_d       = frame_q;
        cnt_d         = cnt_q;
        n_d           = n_q;
        frame_done_d  = 1'b0;
        frame_clear_d = 1'b0;
        run_done_d    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_width != '0 && cfg_height != '0 && cfg_num_frames != 8'd0) begin
                            width_d   = cfg_width;
                            height_d  = cfg_height;
                            xstart_d  = cfg_xstart;
                            ystart_d  = cfg_ystart;
                            xincr_d   = cfg_xincr;
                            yincr_d   = cfg_yincr;
                            nframes_d = cfg_num_frames;
                            pause_d   = cfg_pause;
                            x_d       = '0;
                            y_d       = '0;
                            xr_d      = cfg_xstart;
                            yr_d      = cfg_ystart;
                            frame_d   = 8'd0;
                            mod10_d   = 4'd0;
                            state_d   = S_ISSUE;
                        end else begin
                            run_done_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (eng_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (eng_rsp_valid) begin
                        // Points that never escape are drawn with value 0.
                        n_d     = (int'(eng_rsp_iter) >= MAX_ITER) ? '0 : eng_rsp_iter;
                        state_d = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (pix_ready) begin
                        if (x_q != width_q - DIM_ONE) begin
                            x_d     = x_q + DIM_ONE;
                            xr_d    = xr_q + xincr_q;
                            mod10_d = (mod10_q == 4'd9) ? 4'd0 : mod10_q + 4'd1;
                            state_d = S_ISSUE;
                        end else if (y_q != height_q - DIM_ONE) begin
                            x_d     = '0;
                            mod10_d = 4'd0;
                            xr_d    = xstart_q;
                            y_d     = y_q + DIM_ONE;
                            yr_d    = yr_q + yincr_q;
                            state_d = S_ISSUE;
                        end else begin
                            frame_done_d = 1'b1;
                            cnt_d        = pause_q;
                            state_d      = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (cnt_q != 16'd0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        frame_d = frame_q + 8'd1;
                        if (frame_d == nframes_q) begin
                            state_d = S_IDLE;
                        end else begin
                            x_d     = '0;
                            y_d     = '0;
                            xr_d    = xstart_q;
                            yr_d    = ystart_q;
                            mod10_d = 4'd0;
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // The clear/done strobes belong to the last PAUSE cycle, so they are
        // raised one cycle early, when the counter is about to reach zero.
        if (state_d == S_PAUSE && cnt_d == 16'd0) begin
            frame_clear_d = 1'b1;
            if (frame_q + 8'd1 == nframes_q) run_done_d = 1'b1;
        end
    end

    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            width_q         <= '0;
            height_q        <= '0;
            xstart_q        <= '0;
            ystart_q        <= '0;
            xincr_q         <= '0;
            yincr_q         <= '0;
            nframes_q       <= 8'd0;
            pause_q         <= 16'd0;
            x_q             <= '0;
            y_q             <= '0;
            xr_q            <= '0;
            yr_q            <= '0;
            mod10_q         <= 4'd0;
            frame_q         <= 8'd0;
            cnt_q           <= 16'd0;
            n_q             <= '0;
            eng_req_valid_q <= 1'b0;
            pix_valid_q     <= 1'b0;
            pix_flush_q     <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_clear_q   <= 1'b0;
            run_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            width_q         <= width_d;
            height_q        <= height_d;
            xstart_q        <= xstart_d;
            ystart_q        <= ystart_d;
            xincr_q         <= xincr_d;
            yincr_q         <= yincr_d;
            nframes_q       <= nframes_d;
            pause_q         <= pause_d;
            x_q             <= x_d;
            y_q             <= y_d;
            xr_q            <= xr_d;
            yr_q            <= yr_d;
            mod10_q         <= mod10_d;
            frame_q         <= frame_d;
            cnt_q           <= cnt_d;
            n_q             <= n_d;
            eng_req_valid_q <= (state_d == S_ISSUE);
            pix_valid_q     <= (state_d == S_EMIT);
            pix_flush_q     <= (state_d == S_EMIT) && (mod10_d == 4'd0);
            busy_q          <= (state_d != S_IDLE);
            frame_done_q    <= frame_done_d;
            frame_clear_q   <= frame_clear_d;
            run_done_q      <= run_done_d;
        end
    end

    assign eng_req_valid = eng_req_valid_q;
    assign eng_cre       = xr_q;
    assign eng_cim       = yr_q;
    assign pix_valid     = pix_valid_q;
    assign pix_x         = x_q;
    assign pix_y         = y_q;
    assign pix_n         = n_q;
    assign pix_flush     = pix_flush_q;
    assign frame_done    = frame_done_q;
    assign frame_clear   = frame_clear_q;
    assign busy          = busy_q;
    assign run_done      = run_done_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// tb/tb_mandel_scan_ctrl.sv - directed self-checking bench for mandel_scan_ctrl
module tb_mandel_scan_ctrl;

    logic        sync_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  cfg_width = '0, cfg_height = '0;
    logic [31:0] cfg_xstart = '0, cfg_ystart = '0, cfg_xincr = '0, cfg_yincr = '0;
    logic [7:0]  cfg_num_frames = '0;
    logic [15:0] cfg_pause = '0;
    logic        eng_req_valid, eng_req_ready = 1'b0;
    logic [31:0] eng_cre, eng_cim;
    logic        eng_rsp_valid = 1'b0;
    logic [9:0]  eng_rsp_iter = '0;
    logic        pix_valid, pix_ready = 1'b0;
    logic [9:0]  pix_x, pix_y, pix_n;
    logic        pix_flush, frame_done, frame_clear, busy, run_done;

    mandel_scan_ctrl #(.W_COORD(32), .W_DIM(10), .W_ITER(10), .MAX_ITER(1000)) dut (
        .sync_clk(sync_clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_xstart(cfg_xstart), .cfg_ystart(cfg_ystart),
        .cfg_xincr(cfg_xincr), .cfg_yincr(cfg_yincr),
        .cfg_num_frames(cfg_num_frames), .cfg_pause(cfg_pause),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
        .eng_cre(eng_cre), .eng_cim(eng_cim),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_iter(eng_rsp_iter),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_n(pix_n), .pix_flush(pix_flush),
        .frame_done(frame_done), .frame_clear(frame_clear),
        .busy(busy), .run_done(run_done)
    );

    always #5 sync_clk = ~sync_clk;

    int checks = 0;
    int failures = 0;

    logic [9:0]  rec_x[$], rec_y[$], rec_n[$];
    logic        rec_flush[$];
    logic [31:0] rec_cre[$], rec_cim[$];
    int          rec_fd[$], rec_fc[$], rec_rd[$];
    logic [9:0]  iter_tab[$];
    int          hold_err;
    bit          timed_out;
    logic        busy_after;
    bit          stall_en;
    int          mid_start_cyc;

    task automatic tick();
        @(posedge sync_clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int h, input logic [31:0] xs, input logic [31:0] ys,
                           input logic [31:0] xi, input logic [31:0] yi, input int nf, input int pz);
        cfg_width = 10'(w); cfg_height = 10'(h);
        cfg_xstart = xs; cfg_ystart = ys; cfg_xincr = xi; cfg_yincr = yi;
        cfg_num_frames = 8'(nf); cfg_pause = 16'(pz);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Engine and sink model: records every handshake and strobe by cycle
    // index (0 = first cycle after start) until run_done plus one cycle.
    task automatic run_engine(input int max_cyc);
        bit pending = 0, saw_rd = 0, req_st = 0, pix_st = 0;
        logic [9:0] pend_iter = '0;
        int req_idx = 0;
        logic [31:0] s_cre = '0, s_cim = '0;
        logic [9:0] s_x = '0, s_y = '0, s_n = '0;
        logic s_fl = 1'b0;
        rec_x.delete(); rec_y.delete(); rec_n.delete(); rec_flush.delete();
        rec_cre.delete(); rec_cim.delete(); rec_fd.delete(); rec_fc.delete(); rec_rd.delete();
        hold_err = 0; timed_out = 1'b1; busy_after = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (saw_rd) begin
                busy_after = busy;
                timed_out = 1'b0;
                break;
            end
            if (req_st && (eng_req_valid !== 1'b1 || eng_cre !== s_cre || eng_cim !== s_cim)) hold_err++;
            if (pix_st && (pix_valid !== 1'b1 || pix_x !== s_x || pix_y !== s_y ||
                           pix_n !== s_n || pix_flush !== s_fl)) hold_err++;
            req_st = 0; pix_st = 0;
            if (frame_done === 1'b1) rec_fd.push_back(c);
            if (frame_clear === 1'b1) rec_fc.push_back(c);
            if (run_done === 1'b1) begin rec_rd.push_back(c); saw_rd = 1; end
            start = (c == mid_start_cyc);
            eng_rsp_valid = pending;
            eng_rsp_iter = pending ? pend_iter : 10'd0;
            pending = 0;
            if (eng_req_valid === 1'b1) begin
                eng_req_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (eng_req_ready) begin
                    rec_cre.push_back(eng_cre); rec_cim.push_back(eng_cim);
                    pend_iter = (req_idx < iter_tab.size()) ? iter_tab[req_idx] : 10'd5;
                    req_idx++; pending = 1;
                end else begin
                    req_st = 1; s_cre = eng_cre; s_cim = eng_cim;
                end
            end else begin
                eng_req_ready = 1'b0;
            end
            if (pix_valid === 1'b1) begin
                pix_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (pix_ready) begin
                    rec_x.push_back(pix_x); rec_y.push_back(pix_y);
                    rec_n.push_back(pix_n); rec_flush.push_back(pix_flush);
                end else begin
                    pix_st = 1; s_x = pix_x; s_y = pix_y; s_n = pix_n; s_fl = pix_flush;
                end
            end else begin
                pix_ready = 1'b0;
            end
            tick();
        end
        start = 1'b0; eng_req_ready = 1'b0; eng_rsp_valid = 1'b0; pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (eng_req_valid !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_valids req=%b pix=%b busy=%b required 0 0 0", eng_req_valid, pix_valid, busy);
        end
        checks++;
        if (frame_done !== 1'b0 || frame_clear !== 1'b0 || run_done !== 1'b0 || pix_flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes fd=%b fc=%b rd=%b fl=%b required 0", frame_done, frame_clear, run_done, pix_flush);
        end
        checks++;
        if (eng_cre !== 32'd0 || eng_cim !== 32'd0 || pix_x !== 10'd0 || pix_y !== 10'd0 || pix_n !== 10'd0) begin
            failures++;
            $display("FAIL reset_data cre=%h cim=%h x=%0d y=%0d n=%0d required all 0", eng_cre, eng_cim, pix_x, pix_y, pix_n);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || eng_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle busy=%b req=%b required 0 0", busy, eng_req_valid);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] e_cre, e_cim;
        int ex, ey;
        set_cfg(3, 2, 32'h0000_0000, 32'h1000_0000, 32'h0100_0000, 32'h0080_0000, 1, 0);
        iter_tab.delete(); stall_en = 0; mid_start_cyc = -1;
        pulse_start();
        checks++;
        if (eng_req_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_req req=%b busy=%b required 1 1", eng_req_valid, busy);
        end
        run_engine(200);
        checks++;
        if (timed_out !== 1'b0 || rec_x.size() != 6) begin
            failures++;
            $display("FAIL basic_count timeout=%b pixels=%0d required 0 6", timed_out, rec_x.size());
        end
        for (int k = 0; k < rec_x.size() && k < 6; k++) begin
            ex = k % 3; ey = k / 3;
            e_cre = 32'h0100_0000 * 32'(ex);
            e_cim = 32'h1000_0000 + 32'h0080_0000 * 32'(ey);
            checks++;
            if (rec_x[k] !== 10'(ex) || rec_y[k] !== 10'(ey) || rec_n[k] !== 10'd5 ||
                rec_flush[k] !== (ex == 0) || rec_cre[k] !== e_cre || rec_cim[k] !== e_cim) begin
                failures++;
                $display("FAIL basic_pixel%0d got x=%0d y=%0d n=%0d fl=%b cre=%h cim=%h required %0d %0d 5 %b %h %h",
                         k, rec_x[k], rec_y[k], rec_n[k], rec_flush[k], rec_cre[k], rec_cim[k],
                         ex, ey, ex == 0, e_cre, e_cim);
            end
        end
        checks++;
        if (rec_fd.size() != 1 || rec_fd[0] != 18) begin
            failures++;
            $display("FAIL basic_frame_done count=%0d cyc=%0d required 1 at 18", rec_fd.size(), rec_fd.size() ? rec_fd[0] : -1);
        end
        checks++;
        if (rec_fc.size() != 1 || rec_fc[0] != 18 || rec_rd.size() != 1 || rec_rd[0] != 18) begin
            failures++;
            $display("FAIL basic_clear_done fc=%0d rd=%0d required one each at 18", rec_fc.size(), rec_rd.size());
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_fall busy=%b required 0", busy_after);
        end
    endtask

    task automatic test_in_set();
        logic [9:0] exp_n[3];
        exp_n[0] = 10'd0; exp_n[1] = 10'd999; exp_n[2] = 10'd0;
        set_cfg(3, 1, 32'h0, 32'h0, 32'h0010_0000, 32'h0, 1, 0);
        iter_tab.delete();
        iter_tab.push_back(10'd1000); iter_tab.push_back(10'd999); iter_tab.push_back(10'd1023);
        stall_en = 0; mid_start_cyc = -1;
        pulse_start();
        run_engine(200);
        checks++;
        if (timed_out !== 1'b0 || rec_n.size() != 3) begin
            failures++;
            $display("FAIL inset_count timeout=%b pixels=%0d required 0 3", timed_out, rec_n.size());
        end
        for (int k = 0; k < rec_n.size() && k < 3; k++) begin
            checks++;
            if (rec_n[k] !== exp_n[k]) begin
                failures++;
                $display("FAIL inset_n%0d got %0d required %0d", k, rec_n[k], exp_n[k]);
            end
        end
    endtask

    task automatic test_flush_backpressure();
        int nfl = 0, bad = 0;
        logic [31:0] e_cre;
        set_cfg(25, 1, 32'h7FFF_FFF0, 32'hF000_0000, 32'h0000_0008, 32'h0, 1, 2);
        iter_tab.delete(); stall_en = 1; mid_start_cyc = -1;
        pulse_start();
        run_engine(3000);
        stall_en = 0;
        checks++;
        if (timed_out !== 1'b0 || rec_x.size() != 25) begin
            failures++;
            $display("FAIL flush_count timeout=%b pixels=%0d required 0 25", timed_out, rec_x.size());
        end
        for (int k = 0; k < rec_x.size(); k++) begin
            e_cre = 32'h7FFF_FFF0 + 32'h8 * 32'(k);
            if (rec_flush[k]) nfl++;
            if (rec_x[k] !== 10'(k) || rec_flush[k] !== (k % 10 == 0) || rec_cre[k] !== e_cre ||
                rec_cim[k] !== 32'hF000_0000) bad++;
        end
        checks++;
        if (nfl != 3 || bad != 0) begin
            failures++;
            $display("FAIL flush_cadence flushes=%0d bad_pixels=%0d required 3 0", nfl, bad);
        end
        checks++;
        if (rec_cre.size() > 2 && rec_cre[2] !== 32'h8000_0000) begin
            failures++;
            $display("FAIL flush_coord_wrap cre=%h required 80000000", rec_cre[2]);
        end
        checks++;
        if (hold_err != 0) begin
            failures++;
            $display("FAIL stall_hold changes=%0d required 0", hold_err);
        end
    endtask

    task automatic test_multi_frame();
        set_cfg(2, 2, 32'hFE00_0000, 32'h0100_0000, 32'h0040_0000, 32'h0020_0000, 2, 4);
        iter_tab.delete(); stall_en = 0; mid_start_cyc = -1;
        pulse_start();
        run_engine(300);
        checks++;
        if (timed_out !== 1'b0 || rec_x.size() != 8) begin
            failures++;
            $display("FAIL multi_count timeout=%b pixels=%0d required 0 8", timed_out, rec_x.size());
        end
        checks++;
        if (rec_fd.size() != 2 || rec_fc.size() != 2 || rec_fd[0] != 12 || rec_fc[0] != 16 ||
            rec_fd[1] != 29 || rec_fc[1] != 33) begin
            failures++;
            $display("FAIL multi_pause fd=%0d/%0d fc=%0d/%0d required fd 12,29 fc 16,33",
                     rec_fd.size(), rec_fd.size() ? rec_fd[0] : -1, rec_fc.size(), rec_fc.size() ? rec_fc[0] : -1);
        end
        checks++;
        if (rec_rd.size() != 1 || rec_rd[0] != 33) begin
            failures++;
            $display("FAIL multi_run_done count=%0d required one at 33", rec_rd.size());
        end
        checks++;
        if (rec_x.size() > 4 && (rec_x[4] !== 10'd0 || rec_y[4] !== 10'd0 ||
            rec_cre[4] !== 32'hFE00_0000 || rec_cim[4] !== 32'h0100_0000)) begin
            failures++;
            $display("FAIL multi_restart x=%0d y=%0d cre=%h cim=%h required 0 0 fe000000 01000000",
                     rec_x[4], rec_y[4], rec_cre[4], rec_cim[4]);
        end
        checks++;
        if (rec_cim.size() > 7 && rec_cim[7] !== 32'h0120_0000) begin
            failures++;
            $display("FAIL multi_row_cim cim=%h required 01200000", rec_cim[7]);
        end
    endtask

    task automatic test_zero_and_busy_start();
        int reqs = 0;
        set_cfg(4, 0, 32'h0, 32'h0, 32'h1, 32'h1, 1, 0);
        pulse_start();
        checks++;
        if (run_done !== 1'b1 || busy !== 1'b0 || eng_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_cfg rd=%b busy=%b req=%b required 1 0 0", run_done, busy, eng_req_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (eng_req_valid === 1'b1 || run_done === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            failures++;
            $display("FAIL zero_cfg_quiet activity=%0d required 0", reqs);
        end
        set_cfg(2, 1, 32'h0000_1000, 32'h0, 32'h0000_0010, 32'h0, 1, 0);
        iter_tab.delete(); stall_en = 0; mid_start_cyc = 4;
        pulse_start();
        set_cfg(5, 3, 32'h5555_0000, 32'h0, 32'h0000_0100, 32'h0, 3, 7);
        run_engine(200);
        mid_start_cyc = -1;
        checks++;
        if (timed_out !== 1'b0 || rec_x.size() != 2 || rec_rd.size() != 1) begin
            failures++;
            $display("FAIL busy_start_count timeout=%b pixels=%0d rd=%0d required 0 2 1", timed_out, rec_x.size(), rec_rd.size());
        end
        checks++;
        if (rec_cre.size() != 2 || rec_cre[0] !== 32'h0000_1000 || rec_cre[1] !== 32'h0000_1010) begin
            failures++;
            $display("FAIL busy_start_latched n=%0d cre1=%h required 2 00001010", rec_cre.size(), rec_cre.size() > 1 ? rec_cre[1] : 32'h0);
        end
    endtask

    task automatic test_abort_reset();
        int bad = 0;
        set_cfg(2, 1, 32'h1234_0000, 32'h0, 32'h0000_0100, 32'h0, 1, 0);
        pulse_start();
        eng_req_ready = 1'b1; eng_rsp_valid = 1'b1; eng_rsp_iter = 10'd3;
        tick();
        eng_req_ready = 1'b0; eng_rsp_valid = 1'b0; abort = 1'b1;
        checks++;
        if (busy !== 1'b1 || eng_req_valid !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_wait busy=%b req=%b pix=%b required 1 0 0", busy, eng_req_valid, pix_valid);
        end
        tick();
        abort = 1'b0; eng_rsp_valid = 1'b1; eng_rsp_iter = 10'd7;
        checks++;
        if (busy !== 1'b0 || run_done !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%b rd=%b pix=%b required 0 0 0", busy, run_done, pix_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            eng_rsp_valid = 1'b0;
            if (pix_valid !== 1'b0 || busy !== 1'b0 || run_done !== 1'b0 || eng_req_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_late_rsp activity=%0d required 0", bad);
        end
        pulse_start();
        eng_req_ready = 1'b1;
        tick();
        eng_req_ready = 1'b0; eng_rsp_valid = 1'b1; eng_rsp_iter = 10'd9;
        tick();
        eng_rsp_valid = 1'b0; pix_ready = 1'b0;
        checks++;
        if (pix_valid !== 1'b1 || pix_n !== 10'd9 || eng_cre !== 32'h1234_0000) begin
            failures++;
            $display("FAIL reset_pre_emit pix=%b n=%0d cre=%h required 1 9 12340000", pix_valid, pix_n, eng_cre);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_n !== 10'd0 || eng_cre !== 32'd0) begin
            failures++;
            $display("FAIL reset_async pix=%b busy=%b n=%0d cre=%h required 0 0 0 0", pix_valid, busy, pix_n, eng_cre);
        end
        @(negedge sync_clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || run_done !== 1'b0 || frame_done !== 1'b0 || frame_clear !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulse busy=%b rd=%b fd=%b fc=%b required 0", busy, run_done, frame_done, frame_clear);
        end
    endtask

    initial begin
        stall_en = 0;
        mid_start_cyc = -1;
        test_reset();
        test_basic_frame();
        test_in_set();
        test_flush_backpressure();
        test_multi_frame();
        test_zero_and_busy_start();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
